// File: rtl/pixel_write_queue_if.sv
// Painter-side and VGA-adapter-side signals of the pixel write queue.
// The master drives painter requests; the slave is the queue itself.
interface pixel_write_queue_if #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3
);
  logic [X_BITS-1:0]     in_x;
  logic [Y_BITS-1:0]     in_y;
  logic [COLOR_BITS-1:0] in_color;
  logic                  in_enable;
  logic                  clear_req;
  logic [COLOR_BITS-1:0] clear_color;
  logic [X_BITS-1:0]     vga_x;
  logic [Y_BITS-1:0]     vga_y;
  logic [COLOR_BITS-1:0] vga_colour;
  logic                  vga_plot;
  logic                  busy;
  logic                  fifo_full;
  logic [7:0]            drop_count;

  modport master (
    output in_x, in_y, in_color, in_enable, clear_req, clear_color,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, fifo_full, drop_count
  );

  modport slave (
    input  in_x, in_y, in_color, in_enable, clear_req, clear_color,
    output vga_x, vga_y, vga_colour, vga_plot, busy, fifo_full, drop_count
  );
endinterface

// File: rtl/pixel_write_queue.sv
// Turns painter enable edges into queued pixel writes and drains them to the
// VGA adapter one plot per cycle; a full-screen clear pre-empts draining.
module pixel_write_queue #(
  parameter int SCR_WIDTH  = 160,
  parameter int SCR_HEIGHT = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int DEPTH      = 8,
  parameter int ADDR_BITS  = 3
) (
  input logic               Clck,
  input logic               Reset,
  pixel_write_queue_if.slave pw
);
  localparam int ENTRY_W = X_BITS + Y_BITS + COLOR_BITS;
  localparam logic [X_BITS-1:0]    X_LIM    = X_BITS'(SCR_WIDTH);
  localparam logic [Y_BITS-1:0]    Y_LIM    = Y_BITS'(SCR_HEIGHT);
  localparam logic [X_BITS-1:0]    X_LAST   = X_BITS'(SCR_WIDTH - 1);
  localparam logic [Y_BITS-1:0]    Y_LAST   = Y_BITS'(SCR_HEIGHT - 1);
  localparam logic [ADDR_BITS:0]   FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  typedef enum logic {NORMAL, CLEAR} state_t;

  state_t                state;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]    count;
  logic                  en_q;
  logic [X_BITS-1:0]     cx;
  logic [Y_BITS-1:0]     cy;
  logic [COLOR_BITS-1:0] clr_color;
  logic [7:0]            drops;
  logic [X_BITS-1:0]     vga_x_r;
  logic [Y_BITS-1:0]     vga_y_r;
  logic [COLOR_BITS-1:0] vga_colour_r;
  logic                  vga_plot_r;

  logic push_req, in_range, full, pop, push_ok, drop;

  assign push_req = pw.in_enable & ~en_q;
  assign in_range = (pw.in_x < X_LIM) && (pw.in_y < Y_LIM);
  assign full     = (count == FULL_CNT);
  // A pop frees the slot a same-cycle push needs, so full only blocks without one.
  assign pop      = (state == NORMAL) && (count != '0);
  assign push_ok  = push_req && in_range && (!full || pop);
  assign drop     = push_req && !push_ok;

  always_ff @(posedge Clck) begin
    if (push_ok) mem[wr_ptr] <= {pw.in_x, pw.in_y, pw.in_color};
  end

  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      state        <= NORMAL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      en_q         <= 1'b1;
      cx           <= '0;
      cy           <= '0;
      clr_color    <= '0;
      drops        <= '0;
      vga_x_r      <= '0;
      vga_y_r      <= '0;
      vga_colour_r <= '0;
      vga_plot_r   <= 1'b0;
    end else begin
      en_q       <= pw.in_enable;
      vga_plot_r <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (drop && drops != 8'hFF) drops <= drops + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      unique case (state)
        NORMAL: begin
          if (pop) begin
            {vga_x_r, vga_y_r, vga_colour_r} <= mem[rd_ptr];
            vga_plot_r <= 1'b1;
            rd_ptr     <= rd_ptr + 1'b1;
          end
          if (pw.clear_req) begin
            state     <= CLEAR;
            clr_color <= pw.clear_color;
            cx        <= '0;
            cy        <= '0;
          end
        end
        CLEAR: begin
          vga_x_r      <= cx;
          vga_y_r      <= cy;
          vga_colour_r <= clr_color;
          vga_plot_r   <= 1'b1;
          // Row-major sweep; the last pixel hands control back to draining.
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) state <= NORMAL;
            else              cy    <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  assign pw.vga_x      = vga_x_r;
  assign pw.vga_y      = vga_y_r;
  assign pw.vga_colour = vga_colour_r;
  assign pw.vga_plot   = vga_plot_r;
  assign pw.busy       = (state == CLEAR) || (count != '0);
  assign pw.fifo_full  = full;
  assign pw.drop_count = drops;
endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Sits between the board painter and the VGA adapter's write port.
- Converts the painter's level-held print_enable into exactly one queued pixel write per rising edge, and buffers those writes in a FIFO.
- Drives the adapter with one-cycle plot pulses.
- Also sequences a full-screen clear to a background colour on request; clear takes priority over draining the FIFO.

Parameters:
- SCR_WIDTH, 160, visible pixel columns.
- SCR_HEIGHT, 120, visible pixel rows.
- X_BITS, 8, width of x coordinates.
- Y_BITS, 7, width of y coordinates.
- COLOR_BITS, 3, width of colour.
- DEPTH, 8, FIFO entries; must be a power of two.
- ADDR_BITS, 3, log2(DEPTH).

Ports:
- Clck  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- in_x  in  X_BITS  painter x coordinate (paint_x_co).
- in_y  in  Y_BITS  painter y coordinate (paint_y_co).
- in_color  in  COLOR_BITS  painter colour.
- in_enable  in  1  painter print_enable, level; each rising edge is one write.
- clear_req  in  1  single-cycle request to clear the screen.
- clear_color  in  COLOR_BITS  background colour, sampled with clear_req.
- vga_x  out  X_BITS  adapter x.
- vga_y  out  Y_BITS  adapter y.
- vga_colour  out  COLOR_BITS  adapter colour.
- vga_plot  out  1  adapter write strobe, one cycle per pixel.
- busy  out  1  high while clearing or while the FIFO is non-empty.
- fifo_full  out  1  count == DEPTH.
- drop_count  out  8  saturating count of rejected writes.

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0; FIFO empty; count 0; state NORMAL.
  - Edge register en_q = 1, so an enable held high through reset release does not produce a write.
- Edge detect:
  - A push request occurs at a rising Clck where in_enable=1 and en_q=0.
  - en_q <= in_enable every cycle.
  - in_x, in_y and in_color are captured at that same edge.
- Range check: a push request with in_x >= SCR_WIDTH or in_y >= SCR_HEIGHT is dropped and drop_count increments.
- FIFO:
  - Circular buffer, DEPTH entries of {x, y, colour}; read and write pointers are ADDR_BITS wide and wrap naturally; separate count of width ADDR_BITS+1.
  - Push when full and no pop in the same cycle: write dropped, drop_count increments.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: impossible by construction, because pop requires non-empty.
- drop_count saturates at 255; it is cleared only by Reset.
- State NORMAL:
  - If count > 0: pop the head and register vga_x/vga_y/vga_colour with vga_plot=1 for one cycle.
  - Otherwise vga_plot=0.
  - One pixel per cycle maximum.
  - Latency: a push at edge k with the FIFO empty gives vga_plot high after edge k+1.
- NORMAL -> CLEAR:
  - Happens on clear_req=1. The colour register latches clear_color; cx and cy are set to 0.
  - If clear_req and a pop coincide, the pop completes this cycle.
- State CLEAR:
  - Each cycle, emit vga_plot=1 at (cx, cy, colour register).
  - cx increments; at cx == SCR_WIDTH-1, cx wraps to 0 and cy increments.
  - After (SCR_WIDTH-1, SCR_HEIGHT-1) is emitted, return to NORMAL.
  - Exactly SCR_WIDTH*SCR_HEIGHT plots, in row-major order, with no gaps.
  - No pops occur during CLEAR. Pushes are still accepted, and pushes into a full FIFO are dropped.
  - clear_req during CLEAR is ignored; the sweep is not restarted.
- vga_* outputs hold their last values when vga_plot=0.
- busy = (state==CLEAR) || (count != 0).
- fifo_full = (count == DEPTH).
- Reset mid-clear or mid-drain: the outputs, state and FIFO take their reset values immediately.

Test Plan:
- Hold in_enable high for 3 cycles with (10,20,3'b110), FIFO empty -> exactly one vga_plot pulse at (10,20,110), asserted the cycle after the push edge; busy then drops to 0.
- 10 back-to-back enable pulses (high 1 cycle, low 1 cycle) with distinct coordinates, started during a clear -> first 8 are queued in order, last 2 are dropped, drop_count=2; after the clear ends, 8 consecutive plots come out in FIFO order.
- clear_req with clear_color=3'b001 -> 19200 consecutive plots; the first is (0,0), the one at index 159 is (159,0), the one at index 160 is (0,1), the last is (159,119); a second clear_req mid-sweep has no effect.
- Push in_x=160 or in_y=120 -> no plot, drop_count increments; 300 invalid pushes -> drop_count saturates at 255.
- Reset asserted mid-clear with in_enable held high through release -> outputs 0 asynchronously; no plot after release until in_enable falls and rises again.
- FIFO full, then a push and a pop in the same cycle -> count stays 8, no drop, and the new entry is emitted eighth after that cycle.
